conv_frame_ctrl: RTL and testbench

CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

---
 rtl/conv_frame_ctrl_if.sv | 26 ++
 rtl/conv_frame_ctrl.sv | 126 ++++++++++++
 tb/tb_conv_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_frame_ctrl_if.sv
// Stream and control bundle between a frame source and conv_frame_ctrl.
// The master drives pixels and commands; the slave (controller) returns the window stream and status.
interface conv_frame_ctrl_if;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic [7:0]  pxl_in;
  logic        in_ready;
  logic [7:0]  conv_pxl;
  logic        conv_en;
  logic        win_valid;
  logic [15:0] row;
  logic [15:0] col;
  logic        busy;
  logic        done;

  modport master (
    output start, abort, in_valid, pxl_in,
    input  in_ready, conv_pxl, conv_en, win_valid, row, col, busy, done
  );

  modport slave (
    input  start, abort, in_valid, pxl_in,
    output in_ready, conv_pxl, conv_en, win_valid, row, col, busy, done
  );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame controller for a KxK sliding-window convolution over an MxN image.
// It walks raster order, forwards each accepted pixel with its coordinates and flags full windows.
module conv_frame_ctrl #(
  parameter int N = 5,
  parameter int M = 5,
  parameter int K = 3
) (
  input  logic              clk,
  input  logic              reset,
  conv_frame_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [15:0] N_LAST = 16'(N - 1);
  localparam logic [15:0] M_LAST = 16'(M - 1);
  localparam logic [15:0] K_LAST = 16'(K - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] row_cnt_q, row_cnt_d;
  logic [15:0] col_cnt_q, col_cnt_d;
  logic [7:0]  conv_pxl_q, conv_pxl_d;
  logic [15:0] row_q, row_d;
  logic [15:0] col_q, col_d;
  logic        conv_en_q, conv_en_d;
  logic        win_valid_q, win_valid_d;

  logic in_ready;
  logic accept;
  logic last_pxl;

  assign in_ready = (state_q == RUN);
  assign accept   = bus.in_valid & in_ready;
  assign last_pxl = (row_cnt_q == M_LAST) && (col_cnt_q == N_LAST);

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    col_cnt_d   = col_cnt_q;
    conv_pxl_d  = conv_pxl_q;
    row_d       = row_q;
    col_d       = col_q;
    conv_en_d   = accept;
    win_valid_d = 1'b0;

    if (accept) begin
      conv_pxl_d  = bus.pxl_in;
      row_d       = row_cnt_q;
      col_d       = col_cnt_q;
      win_valid_d = (row_cnt_q >= K_LAST) && (col_cnt_q >= K_LAST);
      if (col_cnt_q == N_LAST) begin
        col_cnt_d = 16'd0;
        row_cnt_d = row_cnt_q + 16'd1;
      end else begin
        col_cnt_d = col_cnt_q + 16'd1;
      end
    end

    // Leaving RUN always clears the counters so they never step past the image edge.
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d   = RUN;
          row_cnt_d = 16'd0;
          col_cnt_d = 16'd0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d   = IDLE;
          row_cnt_d = 16'd0;
          col_cnt_d = 16'd0;
        end else if (accept && last_pxl) begin
          state_d   = DONE;
          row_cnt_d = 16'd0;
          col_cnt_d = 16'd0;
        end
      end
      DONE: begin
        state_d   = IDLE;
        row_cnt_d = 16'd0;
        col_cnt_d = 16'd0;
      end
      default: begin
        state_d   = IDLE;
        row_cnt_d = 16'd0;
        col_cnt_d = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_cnt_q   <= 16'd0;
      col_cnt_q   <= 16'd0;
      conv_pxl_q  <= 8'd0;
      row_q       <= 16'd0;
      col_q       <= 16'd0;
      conv_en_q   <= 1'b0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      conv_pxl_q  <= conv_pxl_d;
      row_q       <= row_d;
      col_q       <= col_d;
      conv_en_q   <= conv_en_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.conv_pxl  = conv_pxl_q;
  assign bus.conv_en   = conv_en_q;
  assign bus.win_valid = win_valid_q;
  assign bus.row       = row_q;
  assign bus.col       = col_q;
  assign bus.busy      = (state_q != IDLE);
  // An abort landing on the DONE cycle cancels the completion pulse.
  assign bus.done      = (state_q == DONE) && !bus.abort;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl: a fixed vector table, directed frame sequences,
// and random traffic against a frame-progress reference model.
module tb_conv_frame_ctrl;
  localparam int N  = 5;
  localparam int M  = 5;
  localparam int K  = 3;
  localparam int MN = N * M;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  conv_frame_ctrl_if bus ();
  conv_frame_ctrl_if bus2 ();

  conv_frame_ctrl #(.N(N), .M(M), .K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  conv_frame_ctrl #(.N(6), .M(4), .K(3)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct {
    bit         start;
    bit         abort;
    bit         valid;
    logic [7:0] pxl;
    bit         e_ready;
    bit         e_busy;
    bit         e_en;
    bit         e_wv;
    logic [7:0] e_pxl;
    int         e_row;
    int         e_col;
  } vec_t;

  vec_t vecs[10];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a frame is either idle or has consumed m_count pixels; m_count == MN is the done cycle.
  bit         m_in_frame;
  int         m_count;
  bit         m_en;
  bit         m_wv;
  logic [7:0] m_pxl;
  int         m_row;
  int         m_col;

  int obs_en, obs_wv, obs_done, first_wv;

  function automatic vec_t mk(bit s, bit a, bit v, logic [7:0] p, bit rdy, bit bsy,
                              bit en, bit wv, logic [7:0] ep, int er, int ec);
    vec_t t;
    t.start = s; t.abort = a; t.valid = v; t.pxl = p;
    t.e_ready = rdy; t.e_busy = bsy; t.e_en = en; t.e_wv = wv;
    t.e_pxl = ep; t.e_row = er; t.e_col = ec;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void model_reset();
    m_in_frame = 1'b0; m_count = 0; m_en = 1'b0; m_wv = 1'b0;
    m_pxl = 8'd0; m_row = 0; m_col = 0;
  endfunction

  function automatic void clear_obs();
    obs_en = 0; obs_wv = 0; obs_done = 0; first_wv = 0;
  endfunction

  task automatic check_all_zero(input string tag);
    check_output({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check_output({tag, "_busy"},     32'(bus.busy), 32'd0);
    check_output({tag, "_done"},     32'(bus.done), 32'd0);
    check_output({tag, "_conv_en"},  32'(bus.conv_en), 32'd0);
    check_output({tag, "_win_valid"},32'(bus.win_valid), 32'd0);
    check_output({tag, "_conv_pxl"}, 32'(bus.conv_pxl), 32'd0);
    check_output({tag, "_row"},      32'(bus.row), 32'd0);
    check_output({tag, "_col"},      32'(bus.col), 32'd0);
  endtask

  task automatic apply_vector(input vec_t v, input int idx);
    @(negedge clk);
    bus.start = v.start; bus.abort = v.abort; bus.in_valid = v.valid; bus.pxl_in = v.pxl;
    #1;
    check_output($sformatf("vec%0d_in_ready", idx), 32'(bus.in_ready), 32'(v.e_ready));
    check_output($sformatf("vec%0d_busy", idx), 32'(bus.busy), 32'(v.e_busy));
    check_output($sformatf("vec%0d_done", idx), 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    check_output($sformatf("vec%0d_conv_en", idx), 32'(bus.conv_en), 32'(v.e_en));
    check_output($sformatf("vec%0d_win_valid", idx), 32'(bus.win_valid), 32'(v.e_wv));
    check_output($sformatf("vec%0d_conv_pxl", idx), 32'(bus.conv_pxl), 32'(v.e_pxl));
    check_output($sformatf("vec%0d_row", idx), 32'(bus.row), 32'(v.e_row));
    check_output($sformatf("vec%0d_col", idx), 32'(bus.col), 32'(v.e_col));
  endtask

  task automatic apply_stimulus(input bit s, input bit a, input bit v, input logic [7:0] p);
    bit acc;
    bit exp_ready;
    @(negedge clk);
    bus.start = s; bus.abort = a; bus.in_valid = v; bus.pxl_in = p;
    #1;
    exp_ready = m_in_frame && (m_count < MN);
    check_output("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check_output("busy", 32'(bus.busy), 32'(m_in_frame));
    check_output("done", 32'(bus.done), 32'(m_in_frame && (m_count == MN) && !a));
    if (bus.done) obs_done++;
    acc  = v && exp_ready;
    m_en = acc;
    m_wv = 1'b0;
    if (acc) begin
      m_pxl = p;
      m_row = m_count / N;
      m_col = m_count % N;
      m_wv  = (m_row >= K - 1) && (m_col >= K - 1);
    end
    if (m_in_frame) begin
      if (a || m_count == MN) begin
        m_in_frame = 1'b0;
        m_count    = 0;
      end else if (acc) begin
        m_count++;
      end
    end else if (s && !a) begin
      m_in_frame = 1'b1;
      m_count    = 0;
    end
    @(posedge clk);
    #1;
    check_output("conv_en", 32'(bus.conv_en), 32'(m_en));
    check_output("win_valid", 32'(bus.win_valid), 32'(m_wv));
    check_output("conv_pxl", 32'(bus.conv_pxl), 32'(m_pxl));
    check_output("row", 32'(bus.row), 32'(m_row));
    check_output("col", 32'(bus.col), 32'(m_col));
    if (bus.conv_en) begin
      obs_en++;
      if (bus.win_valid) begin
        obs_wv++;
        if (first_wv == 0) first_wv = obs_en;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.pxl_in = 0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic check_frame(input string tag, input int e_en, input int e_wv, input int e_done,
                             input int e_first);
    check_output({tag, "_en_count"}, 32'(obs_en), 32'(e_en));
    check_output({tag, "_wv_count"}, 32'(obs_wv), 32'(e_wv));
    check_output({tag, "_done_count"}, 32'(obs_done), 32'(e_done));
    check_output({tag, "_first_wv"}, 32'(first_wv), 32'(e_first));
  endtask

  initial begin
    int en2, wv2, done2, pos_err2;

    vecs[0] = mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    vecs[1] = mk(0, 0, 1, 8'hA1, 1, 1, 1, 0, 8'hA1, 0, 0);
    vecs[2] = mk(0, 0, 0, 8'h00, 1, 1, 0, 0, 8'hA1, 0, 0);
    vecs[3] = mk(1, 0, 1, 8'hB2, 1, 1, 1, 0, 8'hB2, 0, 1);
    vecs[4] = mk(0, 1, 1, 8'hC3, 1, 1, 1, 0, 8'hC3, 0, 2);
    vecs[5] = mk(0, 0, 1, 8'h55, 0, 0, 0, 0, 8'hC3, 0, 2);
    vecs[6] = mk(1, 1, 0, 8'h00, 0, 0, 0, 0, 8'hC3, 0, 2);
    vecs[7] = mk(0, 0, 1, 8'h66, 0, 0, 0, 0, 8'hC3, 0, 2);
    vecs[8] = mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'hC3, 0, 2);
    vecs[9] = mk(0, 0, 1, 8'hD4, 1, 1, 1, 0, 8'hD4, 0, 0);

    bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.pxl_in = 0;
    bus2.start = 0; bus2.abort = 0; bus2.in_valid = 0; bus2.pxl_in = 0;
    model_reset();
    clear_obs();

    #12;
    check_all_zero("por");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) apply_vector(vecs[i], i);

    // Full frame with in_valid held high.
    do_reset();
    clear_obs();
    apply_stimulus(1, 0, 0, 8'h00);
    for (int i = 0; i < 30; i++) apply_stimulus(0, 0, 1, 8'($urandom));
    check_frame("solid", 25, 9, 1, 13);

    // Full frame with a bubble every other cycle.
    clear_obs();
    apply_stimulus(1, 0, 0, 8'h00);
    for (int i = 0; i < 56; i++) apply_stimulus(0, 0, (i % 2) == 0, 8'(i / 2));
    check_frame("bubbly", 25, 9, 1, 13);

    // Abort after ten accepts, with an eleventh pixel offered on the abort cycle.
    clear_obs();
    apply_stimulus(1, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) apply_stimulus(0, 0, 1, 8'(8'h30 + i));
    apply_stimulus(0, 1, 1, 8'h7E);
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 1, 8'h11);
    check_output("abort_en_count", 32'(obs_en), 32'd11);
    check_output("abort_done_count", 32'(obs_done), 32'd0);
    apply_stimulus(1, 0, 0, 8'h00);
    apply_stimulus(0, 0, 1, 8'h99);

    // Stray start pulses mid-frame.
    do_reset();
    clear_obs();
    apply_stimulus(1, 0, 0, 8'h00);
    for (int i = 0; i < 30; i++) apply_stimulus((i == 5) || (i == 12), 0, 1, 8'($urandom));
    check_frame("restart", 25, 9, 1, 13);

    // Asynchronous reset between clock edges in the middle of a frame.
    clear_obs();
    apply_stimulus(1, 0, 0, 8'h00);
    for (int i = 0; i < 7; i++) apply_stimulus(0, 0, 1, 8'(8'h40 + i));
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    clear_obs();
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 1, 8'h22);
    check_output("post_rst_done_count", 32'(obs_done), 32'd0);
    check_output("post_rst_en_count", 32'(obs_en), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 500; i++)
      apply_stimulus($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                     $urandom_range(0, 1) == 1, 8'($urandom));

    // Non-square instance: 4 rows by 6 columns.
    do_reset();
    en2 = 0; wv2 = 0; done2 = 0; pos_err2 = 0;
    @(negedge clk);
    bus2.start = 1;
    @(negedge clk);
    bus2.start = 0;
    bus2.in_valid = 1;
    for (int i = 0; i < 35; i++) begin
      bus2.pxl_in = 8'(i);
      #1;
      if (bus2.done) done2++;
      @(posedge clk);
      #1;
      if (bus2.conv_en) begin
        if ((int'(bus2.row) != en2 / 6) || (int'(bus2.col) != en2 % 6)) pos_err2++;
        en2++;
        if (bus2.win_valid) wv2++;
      end
      @(negedge clk);
    end
    bus2.in_valid = 0;
    check_output("n6m4_en_count", 32'(en2), 32'd24);
    check_output("n6m4_wv_count", 32'(wv2), 32'd8);
    check_output("n6m4_done_count", 32'(done2), 32'd1);
    check_output("n6m4_position_errors", 32'(pos_err2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
